// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient loader.
//   SLOT_W      : width of one coefficient slot in the packed output bus
//   fir_state_e : loader FSM state encoding
//   sext_word   : sign-extend the low 'cw' bits of a slot-wide word
// Optional feature macro: FIR_COEF_LOADER_CHECKSUM_EN (adds the CHECK state).
package fir_pkg;

  localparam int unsigned SLOT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
    ST_CHECK  = 2'd2,
`endif
    ST_COMMIT = 2'd3
  } fir_state_e;

  // Bits at or above cw are replaced by bit cw-1 (cw in 1..SLOT_W).
  function automatic logic [SLOT_W-1:0] sext_word(input logic [SLOT_W-1:0] w,
                                                  input int unsigned       cw);
    logic [SLOT_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < SLOT_W; b++) begin
      r[b] = (b < cw) ? w[b] : w[cw-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_coef_loader.sv
// FIR coefficient loader: collects a set of TAPS coefficient words into a
// shadow register file over a valid/ready stream, then swaps the whole set
// into the active output bus in a single cycle so consumers never observe a
// partially updated set.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   s_valid/ready : word handshake (transfer when both high at rising edge)
//   s_data        : coefficient word, significant bits [CWIDTH-1:0]
//   s_first       : word is index 0 of a new set
//   coefs         : active set, index i at slot (TAPS-1-i)
//   coefs_valid   : sticky, set by the first commit after reset
//   load_done     : one-cycle pulse when a set commits
//   load_err      : one-cycle pulse when a word or partial set is dropped
//
// Optional feature macro: FIR_COEF_LOADER_CHECKSUM_EN
//   When defined, each set is followed by one checksum word that must equal
//   the XOR of the TAPS raw data words; a mismatch drops the set.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int unsigned TAPS   = 3,
  parameter int unsigned CWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [SLOT_W-1:0]        s_data,
  input  logic                     s_first,
  output logic [TAPS*SLOT_W-1:0]   coefs,
  output logic                     coefs_valid,
  output logic                     load_done,
  output logic                     load_err
);

  localparam int unsigned CNT_W = $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);

  // State entered once the final coefficient word of a set is taken.
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
  localparam fir_state_e ST_FULL = ST_CHECK;
`else
  localparam fir_state_e ST_FULL = ST_COMMIT;
`endif

  fir_state_e            state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [SLOT_W-1:0]     shadow_q [TAPS];
  logic [TAPS*SLOT_W-1:0] coefs_q;
  logic [TAPS*SLOT_W-1:0] shadow_flat;
  logic                  coefs_valid_q;
  logic                  load_done_q, load_done_d;
  logic                  load_err_q, load_err_d;
  logic                  s_ready_q;
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
  logic [SLOT_W-1:0]     xor_q, xor_d;
`endif

  logic                  hs_c;
  logic                  shadow_we_c;
  logic [CNT_W-1:0]      shadow_idx_c;
  logic [SLOT_W-1:0]     word_ext_c;

  assign hs_c       = s_valid & s_ready_q;
  assign word_ext_c = sext_word(s_data, CWIDTH);

  // Next-state, shadow write control and pulse generation.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    load_done_d  = 1'b0;
    load_err_d   = 1'b0;
    shadow_we_c  = 1'b0;
    shadow_idx_c = '0;
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
    xor_d        = xor_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (hs_c) begin
          if (s_first) begin
            shadow_we_c = 1'b1;
            count_d     = CNT_ONE;
            state_d     = (TAPS == 1) ? ST_FULL : ST_LOAD;
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
            xor_d       = s_data;
`endif
          end else begin
            load_err_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (hs_c) begin
          if (s_first) begin
            // New set preempts the partial one.
            load_err_d  = 1'b1;
            shadow_we_c = 1'b1;
            count_d     = CNT_ONE;
            state_d     = (TAPS == 1) ? ST_FULL : ST_LOAD;
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
            xor_d       = s_data;
`endif
          end else begin
            shadow_we_c  = 1'b1;
            shadow_idx_c = count_q;
            count_d      = count_q + CNT_ONE;
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
            xor_d        = xor_q ^ s_data;
`endif
            if (count_q == CNT_LAST) begin
              state_d = ST_FULL;
            end
          end
        end
      end

`ifdef FIR_COEF_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (hs_c) begin
          if (s_first) begin
            load_err_d  = 1'b1;
            shadow_we_c = 1'b1;
            count_d     = CNT_ONE;
            xor_d       = s_data;
            state_d     = (TAPS == 1) ? ST_FULL : ST_LOAD;
          end else if (s_data == xor_q) begin
            state_d = ST_COMMIT;
          end else begin
            load_err_d = 1'b1;
            count_d    = '0;
            state_d    = ST_IDLE;
          end
        end
      end
`endif

      ST_COMMIT: begin
        load_done_d = 1'b1;
        count_d     = '0;
        state_d     = ST_IDLE;
      end

      default: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Slot i of the shadow file lands at bus slot TAPS-1-i.
  always_comb begin
    shadow_flat = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      shadow_flat[(TAPS-1-i)*SLOT_W +: SLOT_W] = shadow_q[i];
    end
  end

  // Control state and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      coefs_q       <= '0;
      coefs_valid_q <= 1'b0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
      s_ready_q     <= 1'b1;
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
      xor_q         <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      // Ready mirrors the next state so it is valid straight out of a flop.
      s_ready_q   <= (state_d != ST_COMMIT);
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
      if (state_q == ST_COMMIT) begin
        coefs_q       <= shadow_flat;
        coefs_valid_q <= 1'b1;
      end
    end
  end

  // Shadow register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        if (shadow_we_c && (shadow_idx_c == CNT_W'(i))) begin
          shadow_q[i] <= word_ext_c;
        end
      end
    end
  end

  assign s_ready     = s_ready_q;
  assign coefs       = coefs_q;
  assign coefs_valid = coefs_valid_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: a TAPS=3/CWIDTH=16 instance and a
// TAPS=3/CWIDTH=8 instance share one input stream. Honours
// FIR_COEF_LOADER_CHECKSUM_EN by appending checksum words to each set.
module tb_fir_coef_loader;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_first;

  logic        s_ready16, coefs_valid16, load_done16, load_err16;
  logic [47:0] coefs16;
  logic        s_ready8, coefs_valid8, load_done8, load_err8;
  logic [47:0] coefs8;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;

  fir_coef_loader #(.TAPS(3), .CWIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready16),
    .s_data(s_data), .s_first(s_first), .coefs(coefs16),
    .coefs_valid(coefs_valid16), .load_done(load_done16), .load_err(load_err16)
  );

  fir_coef_loader #(.TAPS(3), .CWIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready8),
    .s_data(s_data), .s_first(s_first), .coefs(coefs8),
    .coefs_valid(coefs_valid8), .load_done(load_done8), .load_err(load_err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse counters, plus done/err exclusivity on every cycle either fires.
  always @(negedge clk) begin
    if (load_done16) done_cnt++;
    if (load_err16)  err_cnt++;
    if (load_done16 || load_err16) begin
      n_cmp++;
      assert (!(load_done16 && load_err16)) else begin
        n_bad++;
        $error("FAIL done_err_exclusive: observed=both expected=one");
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one word until it is accepted (bounded); returns #1 after the accepting edge.
  task automatic send(input logic [15:0] d, input logic f);
    bit took;
    took    = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_first = f;
    for (int i = 0; i < 8 && !took; i++) begin
      took = (s_ready16 === 1'b1);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_first = 1'b0;
    if (!took) chk("send_timeout", 64'(took), 64'd1);
  endtask

  task automatic send_set(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    send(a, 1'b1);
    send(b, 1'b0);
    send(c, 1'b0);
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
    send(a ^ b ^ c, 1'b0);
`endif
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  int e0, d0, c0;
  logic [47:0] saved;

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_first = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_coefs",       64'(coefs16),       64'h0);
    chk("rst_coefs_valid", 64'(coefs_valid16), 64'h0);
    chk("rst_load_done",   64'(load_done16),   64'h0);
    chk("rst_load_err",    64'(load_err16),    64'h0);
    chk("rst_s_ready",     64'(s_ready16),     64'h1);
    chk("rst_coefs8",      64'(coefs8),        64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic set and commit latency.
    send_set(16'h0001, 16'h0002, 16'h0003);
    chk("b_done_early",   64'(load_done16), 64'h0);
    chk("b_ready_commit", 64'(s_ready16),   64'h0);
    chk("b_coefs_early",  64'(coefs16),     64'h0);
    @(posedge clk); #1;
    chk("b_done",        64'(load_done16),   64'h1);
    chk("b_coefs",       64'(coefs16),       64'h0001_0002_0003);
    chk("b_coefs_valid", 64'(coefs_valid16), 64'h1);
    chk("b_ready_back",  64'(s_ready16),     64'h1);
    @(posedge clk); #1;
    chk("b_done_pulse", 64'(load_done16), 64'h0);

    // Partial set aborted by a new s_first word.
    e0 = err_cnt;
    send(16'h0010, 1'b1);
    send(16'h0020, 1'b0);
    send(16'h0100, 1'b1);
    chk("ab_err_pulse", 64'(load_err16), 64'h1);
    chk("ab_no_mix",    64'(coefs16),    64'h0001_0002_0003);
    send(16'h0200, 1'b0);
    send(16'h0300, 1'b0);
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
    send(16'h0000, 1'b0);
`endif
    @(posedge clk); #1;
    chk("ab_coefs", 64'(coefs16), 64'h0100_0200_0300);
    settle();
    chk("ab_err_count", 64'(err_cnt - e0), 64'd1);

    // Stray non-first words in IDLE.
    send(16'h7777, 1'b0);
    chk("idle_err",   64'(load_err16), 64'h1);
    chk("idle_ready", 64'(s_ready16),  64'h1);
    settle();
    chk("idle_coefs", 64'(coefs16), 64'h0100_0200_0300);
    send(16'h1234, 1'b0);
    chk("idle_err2", 64'(load_err16), 64'h1);

    // Sign extension at CWIDTH=8 versus 16.
    send_set(16'h0080, 16'h007F, 16'h00FF);
    @(posedge clk); #1;
    chk("sx_coefs8",  64'(coefs8),  64'hFF80_007F_FFFF);
    chk("sx_coefs16", 64'(coefs16), 64'h0080_007F_00FF);

    // Back-to-back sets: one bubble per commit.
    @(posedge clk); #1;
    d0 = done_cnt;
    c0 = cyc;
    send_set(16'h0004, 16'h0005, 16'h0006);
    send_set(16'h0007, 16'h0008, 16'h0009);
    @(posedge clk); #1;
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
    chk("bb_cycles", 64'(cyc - c0), 64'd10);
`else
    chk("bb_cycles", 64'(cyc - c0), 64'd8);
`endif
    chk("bb_coefs", 64'(coefs16), 64'h0007_0008_0009);
    settle();
    chk("bb_done_count", 64'(done_cnt - d0), 64'd2);

`ifdef FIR_COEF_LOADER_CHECKSUM_EN
    // Bad checksum drops the set.
    d0 = done_cnt;
    send(16'h0001, 1'b1);
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b0);
    send(16'h0001, 1'b0);
    chk("ck_err",   64'(load_err16), 64'h1);
    chk("ck_ready", 64'(s_ready16),  64'h1);
    settle();
    chk("ck_coefs", 64'(coefs16), 64'h0007_0008_0009);
    chk("ck_done",  64'(done_cnt - d0), 64'd0);
`endif

    // Reset in the middle of a set.
    send(16'h0005, 1'b1);
    send(16'h0006, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_coefs",       64'(coefs16),       64'h0);
    chk("mr_coefs_valid", 64'(coefs_valid16), 64'h0);
    chk("mr_load_done",   64'(load_done16),   64'h0);
    chk("mr_load_err",    64'(load_err16),    64'h0);
    chk("mr_s_ready",     64'(s_ready16),     64'h1);
    chk("mr_coefs8",      64'(coefs8),        64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h0009, 1'b0);
    chk("mr_err_after", 64'(load_err16), 64'h1);
    settle();
    chk("mr_valid_after", 64'(coefs_valid16), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
